seq_detector_param: RTL

Parametrised synchronous sequence detector: the next generation of our hand-built 2-bit Mealy detector, generalised to SYM_W-bit symbols and a DEPTH-symbol pattern. It watches a qualified symbol stream, raises a registered one-cycle match pulse, and optionally keeps a saturating match count. Overlap and non-overlap modes are selectable at run time. It sits between the input-conditioning logic and the display/counter logic of the lab top level.

---
 rtl/seq_detector_param_if.sv | 29 ++
 rtl/seq_detector_param.sv | 93 +++++++++
 2 files changed

// File: rtl/seq_detector_param_if.sv
// Symbol-stream bundle for seq_detector_param.
// Carries the qualified symbol input and run-time configuration in one direction,
// and the match pulse, fill level and match count in the other.
interface seq_detector_param_if #(
    parameter int SYM_W  = 2,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 8,
    parameter int FILL_W = $clog2(DEPTH + 1)
);
    logic [SYM_W-1:0]       x;
    logic                   in_valid;
    logic [DEPTH*SYM_W-1:0] pattern;
    logic                   overlap;
    logic                   z;
    logic [FILL_W-1:0]      pS;
    logic [CNT_W-1:0]       match_count;

    // The source side drives symbols and configuration.
    modport master (
        output x, in_valid, pattern, overlap,
        input  z, pS, match_count
    );

    // The detector side consumes symbols and reports matches.
    modport slave (
        input  x, in_valid, pattern, overlap,
        output z, pS, match_count
    );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised sequence detector.
// Shifts SYM_W-bit symbols into a DEPTH-symbol history and pulses z for one cycle
// on the edge that accepts the last symbol of a match against 'pattern'.
// Optional feature macro SEQDET_COUNT_EN: when defined, a saturating match
// counter is built; otherwise match_count is tied to zero.
module seq_detector_param #(
    parameter int SYM_W  = 2,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 8,
    parameter int FILL_W = $clog2(DEPTH + 1)
) (
    input logic                 clock,
    input logic                 clear,
    seq_detector_param_if.slave bus
);

    logic [DEPTH*SYM_W-1:0] hist;
    logic [DEPTH*SYM_W-1:0] window;
    logic [FILL_W-1:0]      fill;
    logic [FILL_W-1:0]      fill_next;
    logic                   z_reg;
    logic                   hit;

    // The window is the history as it would look after accepting x; it is both
    // the compare operand and the next history value.
    generate
        if (DEPTH == 1) begin : g_single
            assign window = bus.x;
        end else begin : g_multi
            assign window = {hist[(DEPTH-1)*SYM_W-1:0], bus.x};
        end
    endgenerate

    // Match only counts once enough live symbols are held; the fill level masks
    // stale history left behind after a non-overlapping restart.
    always_comb begin
        hit = 1'b0;
        if (bus.in_valid && (fill >= FILL_W'(DEPTH - 1)) && (window == bus.pattern)) begin
            hit = 1'b1;
        end
    end

    // Next fill level: restart on a non-overlapping match, pin full on an
    // overlapping one, otherwise count up and saturate at DEPTH.
    always_comb begin
        fill_next = fill;
        if (bus.in_valid) begin
            if (hit) begin
                fill_next = bus.overlap ? FILL_W'(DEPTH) : '0;
            end else if (fill >= FILL_W'(DEPTH)) begin
                fill_next = FILL_W'(DEPTH);
            end else begin
                fill_next = fill + 1'b1;
            end
        end
    end

    // History, fill level and the registered match pulse.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            hist  <= '0;
            fill  <= '0;
            z_reg <= 1'b0;
        end else begin
            z_reg <= hit;
            fill  <= fill_next;
            if (bus.in_valid) begin
                hist <= window;
            end
        end
    end

    assign bus.z  = z_reg;
    assign bus.pS = fill;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] count;

    // Saturating match counter; holds at all-ones instead of wrapping.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (hit && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign bus.match_count = count;
`else
    assign bus.match_count = '0;
`endif

endmodule
